// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned MaxWidth = 128;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StRun,
    StFixup,
    StDone
  } div_state_e;

  typedef struct packed {
    logic [DefWidth-1:0] quot;
    logic [DefWidth-1:0] rem;
    logic                div_by_zero;
    logic                overflow;
  } div_result_t;

  // Most negative two's-complement value for a given width, right-aligned.
  function automatic logic [MaxWidth-1:0] min_val(input int unsigned width);
    logic [MaxWidth-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/seq_divider_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module seq_divider_restore_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             num_bit_i,
  input  logic [WIDTH-1:0] denom_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;

  // The partial remainder is always below denom, so the shift fits in WIDTH+1 bits.
  always_comb begin
    shifted = {rem_i, num_bit_i};
    q_bit_o = (shifted >= {1'b0, denom_i});
    rem_o   = q_bit_o ? (shifted[WIDTH-1:0] - denom_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready on both sides.
// Define SEQ_DIVIDER_EARLY_OUT_EN to skip RUN for trivial operand combinations.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned ITERS_PER_CYCLE = 1,
  parameter int unsigned CNT_W           = $clog2(WIDTH / ITERS_PER_CYCLE) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_cmd_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_denom,
  output logic             out_valid,
  input  logic             in_result_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_by_zero,
  output logic             out_overflow
);

  localparam int unsigned NumRun = WIDTH / ITERS_PER_CYCLE;
  localparam logic [WIDTH-1:0] MinVal = WIDTH'(min_val(WIDTH));

  if ((WIDTH % ITERS_PER_CYCLE) != 0 || WIDTH < 8 || WIDTH > 128) begin : g_param_check
    $error("seq_divider: WIDTH must be 8..128 and a multiple of ITERS_PER_CYCLE");
  end

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d, den_q, den_d;
  logic             signed_q, signed_d, num_neg_q, num_neg_d, den_neg_q, den_neg_d;
  logic [WIDTH-1:0] num_sh_q, num_sh_d, den_mag_q, den_mag_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] out_quot_q, out_quot_d, out_rem_q, out_rem_d;
  logic             out_dbz_q, out_dbz_d, out_ovf_q, out_ovf_d;

  logic [WIDTH-1:0]           rem_chain [ITERS_PER_CYCLE+1];
  logic [ITERS_PER_CYCLE-1:0] q_bits;
  logic [WIDTH-1:0]           num_mag_c, den_mag_c;
  logic                       is_dbz_c, is_ovf_c, early_c;

  assign rem_chain[0] = rem_q;

  for (genvar k = 0; k < ITERS_PER_CYCLE; k++) begin : g_step
    seq_divider_restore_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .rem_i    (rem_chain[k]),
      .num_bit_i(num_sh_q[WIDTH-1-k]),
      .denom_i  (den_mag_q),
      .rem_o    (rem_chain[k+1]),
      .q_bit_o  (q_bits[ITERS_PER_CYCLE-1-k])
    );
  end

  always_comb begin
    num_mag_c = num_neg_q ? (~num_q + 1'b1) : num_q;
    den_mag_c = den_neg_q ? (~den_q + 1'b1) : den_q;
    is_dbz_c  = (den_q == '0);
    is_ovf_c  = signed_q && (num_q == MinVal) && (den_q == '1);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    early_c   = is_dbz_c || is_ovf_c || (num_mag_c < den_mag_c);
`else
    early_c   = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    den_d      = den_q;
    signed_d   = signed_q;
    num_neg_d  = num_neg_q;
    den_neg_d  = den_neg_q;
    num_sh_d   = num_sh_q;
    den_mag_d  = den_mag_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    out_dbz_d  = out_dbz_q;
    out_ovf_d  = out_ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          num_d     = in_num;
          den_d     = in_denom;
          signed_d  = in_signed;
          num_neg_d = in_signed & in_num[WIDTH-1];
          den_neg_d = in_signed & in_denom[WIDTH-1];
          state_d   = StPrep;
        end
      end
      StPrep: begin
        num_sh_d  = num_mag_c;
        den_mag_d = den_mag_c;
        rem_d     = '0;
        quot_d    = '0;
        cnt_d     = CNT_W'(NumRun);
        dbz_d     = is_dbz_c;
        ovf_d     = is_ovf_c;
        if (early_c) begin
          rem_d   = num_mag_c;
          state_d = StFixup;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        num_sh_d = num_sh_q << ITERS_PER_CYCLE;
        rem_d    = rem_chain[ITERS_PER_CYCLE];
        quot_d   = (quot_q << ITERS_PER_CYCLE) | WIDTH'(q_bits);
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StFixup;
      end
      StFixup: begin
        out_dbz_d = dbz_q;
        out_ovf_d = ovf_q;
        if (dbz_q) begin
          out_quot_d = '1;
          out_rem_d  = num_q;
        end else if (ovf_q) begin
          out_quot_d = MinVal;
          out_rem_d  = '0;
        end else begin
          // Truncating division: remainder takes the dividend's sign.
          out_quot_d = (num_neg_q ^ den_neg_q) ? (~quot_q + 1'b1) : quot_q;
          out_rem_d  = num_neg_q ? (~rem_q + 1'b1) : rem_q;
        end
        state_d = StDone;
      end
      StDone: begin
        if (in_result_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      num_q      <= '0;
      den_q      <= '0;
      signed_q   <= 1'b0;
      num_neg_q  <= 1'b0;
      den_neg_q  <= 1'b0;
      num_sh_q   <= '0;
      den_mag_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      out_dbz_q  <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      den_q      <= den_d;
      signed_q   <= signed_d;
      num_neg_q  <= num_neg_d;
      den_neg_q  <= den_neg_d;
      num_sh_q   <= num_sh_d;
      den_mag_q  <= den_mag_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      out_dbz_q  <= out_dbz_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign out_cmd_ready   = (state_q == StIdle);
  assign out_valid       = (state_q == StDone);
  assign out_quot        = out_quot_q;
  assign out_rem         = out_rem_q;
  assign out_div_by_zero = out_dbz_q;
  assign out_overflow    = out_ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (32-bit x1 and 64-bit x4 instances).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_signed, in_result_ready;
  logic [31:0] in_num, in_denom;
  logic        out_cmd_ready, out_valid, out_div_by_zero, out_overflow;
  logic [31:0] out_quot, out_rem;

  logic        v64, s64, rr64;
  logic [63:0] n64, d64;
  logic        rdy64, ov64_valid, dbz64, ovf64;
  logic [63:0] q64, r64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .out_cmd_ready  (out_cmd_ready),
    .in_signed      (in_signed),
    .in_num         (in_num),
    .in_denom       (in_denom),
    .out_valid      (out_valid),
    .in_result_ready(in_result_ready),
    .out_quot       (out_quot),
    .out_rem        (out_rem),
    .out_div_by_zero(out_div_by_zero),
    .out_overflow   (out_overflow)
  );

  seq_divider #(
    .WIDTH          (64),
    .ITERS_PER_CYCLE(4)
  ) u_dut64 (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (v64),
    .out_cmd_ready  (rdy64),
    .in_signed      (s64),
    .in_num         (n64),
    .in_denom       (d64),
    .out_valid      (ov64_valid),
    .in_result_ready(rr64),
    .out_quot       (q64),
    .out_rem        (r64),
    .out_div_by_zero(dbz64),
    .out_overflow   (ovf64)
  );

  // Issue one command and count edges from accept until out_valid (200 = timed out).
  task automatic run_cmd(input logic sgn, input logic [31:0] num, input logic [31:0] den,
                         output int lat, output logic ready_seen);
    @(negedge clk);
    in_valid = 1'b1; in_signed = sgn; in_num = num; in_denom = den;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (out_cmd_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    in_result_ready = 1'b1;
    @(posedge clk);
    #1 in_result_ready = 1'b0;
  endtask

  task automatic run_cmd64(input logic sgn, input logic [63:0] num, input logic [63:0] den,
                           output int lat);
    @(negedge clk);
    v64 = 1'b1; s64 = sgn; n64 = num; d64 = den;
    @(posedge clk);
    #1 v64 = 1'b0;
    lat = 0;
    while (!ov64_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    @(negedge clk);
    rr64 = 1'b1;
    @(posedge clk);
    #1 rr64 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_cmd_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_hs: got %b want 10", {out_cmd_ready, out_valid});
    end
    n_checks++;
    if ({out_quot, out_rem, out_div_by_zero, out_overflow} !== 66'd0) begin
      n_fail++; $display("FAIL reset_out: got q=%h r=%h dbz=%b ovf=%b want zeros",
                         out_quot, out_rem, out_div_by_zero, out_overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned_latency();
    int   lat;
    logic rs;
    run_cmd(1'b0, 32'd100, 32'd7, lat, rs);
    n_checks++;
    if (lat !== 34) begin n_fail++; $display("FAIL lat_100_7: got %0d want 34", lat); end
    n_checks++;
    if (rs !== 1'b0) begin n_fail++; $display("FAIL ready_busy: got %b want 0", rs); end
    n_checks++;
    if ({out_quot, out_rem} !== {32'd14, 32'd2}) begin
      n_fail++; $display("FAIL div_100_7: got q=%0d r=%0d want q=14 r=2", out_quot, out_rem);
    end
    consume();
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] num, den, q, r;
    logic        dbz, ovf, early;
  } vec_t;

  task automatic test_vectors();
    vec_t vt[9];
    int   lat;
    logic rs;
    vt[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b1};
    vt[7] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vt[8] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_cmd(vt[i].sgn, vt[i].num, vt[i].den, lat, rs);
      n_checks++;
      if ({out_quot, out_rem} !== {vt[i].q, vt[i].r}) begin
        n_fail++; $display("FAIL vec%0d_qr: got q=%h r=%h want q=%h r=%h",
                           i, out_quot, out_rem, vt[i].q, vt[i].r);
      end
      n_checks++;
      if ({out_div_by_zero, out_overflow} !== {vt[i].dbz, vt[i].ovf}) begin
        n_fail++; $display("FAIL vec%0d_flags: got dbz=%b ovf=%b want dbz=%b ovf=%b",
                           i, out_div_by_zero, out_overflow, vt[i].dbz, vt[i].ovf);
      end
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
      if (!vt[i].early) begin
`else
      begin
`endif
        n_checks++;
        if (lat !== 34) begin n_fail++; $display("FAIL vec%0d_lat: got %0d want 34", i, lat); end
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic rs;
    run_cmd(1'b0, 32'd1000, 32'd10, lat, rs);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); in_num = 32'd77 + i; in_denom = 32'd3;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_cmd_ready, out_quot, out_rem} !== {2'b10, 32'd100, 32'd0}) begin
        n_fail++; $display("FAIL hold%0d: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=100 r=0",
                           i, out_valid, out_cmd_ready, out_quot, out_rem);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_result_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_cmd_ready, out_quot} !== {2'b01, 32'd100}) begin
      n_fail++; $display("FAIL release: got v=%b rdy=%b q=%0d want v=0 rdy=1 q=100",
                         out_valid, out_cmd_ready, out_quot);
    end
    in_result_ready = 1'b0;
    in_valid = 1'b1; in_signed = 1'b0; in_num = 32'd50; in_denom = 32'd6;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_checks++;
    if (out_cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got rdy=%b want 0", out_cmd_ready);
    end
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    n_checks++;
    if (lat !== 34 || {out_quot, out_rem} !== {32'd8, 32'd2}) begin
      n_fail++; $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d want lat=34 q=8 r=2",
                         lat, out_quot, out_rem);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    logic rs;
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b0; in_num = 32'd12345; in_denom = 32'd11;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({out_valid, out_cmd_ready, out_quot, out_rem, out_div_by_zero, out_overflow}
        !== {2'b01, 66'd0}) begin
      n_fail++; $display("FAIL mid_reset: got v=%b rdy=%b q=%h r=%h dbz=%b ovf=%b want 0 1 0 0 0 0",
                         out_valid, out_cmd_ready, out_quot, out_rem,
                         out_div_by_zero, out_overflow);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL discarded: got valid=%b want 0", seen); end
    run_cmd(1'b0, 32'd9, 32'd3, lat, rs);
    n_checks++;
    if ({out_quot, out_rem} !== {32'd3, 32'd0}) begin
      n_fail++; $display("FAIL after_reset_9_3: got q=%0d r=%0d want q=3 r=0", out_quot, out_rem);
    end
    consume();
  endtask

  task automatic test_wide();
    int lat;
    run_cmd64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, lat);
    n_checks++;
    if (lat !== 18 || {q64, r64} !== {64'h5555_5555_5555_5555, 64'd0}) begin
      n_fail++; $display("FAIL w64_max_3: got lat=%0d q=%h r=%h want 18 5555555555555555 0",
                         lat, q64, r64);
    end
    run_cmd64(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, lat);
    n_checks++;
    if ({q64, r64} !== {64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      n_fail++; $display("FAIL w64_m100_7: got q=%h r=%h want fffffffffffffff2 fffffffffffffffe",
                         q64, r64);
    end
    run_cmd64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, lat);
    n_checks++;
    if ({q64, r64} !== {64'hFFFF_FFFF, 64'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL w64_hi_lo: got q=%h r=%h want ffffffff ffffffff", q64, r64);
    end
    run_cmd64(1'b1, 64'h8000_0000_0000_0000, 64'd2, lat);
    n_checks++;
    if ({q64, r64} !== {64'hC000_0000_0000_0000, 64'd0}) begin
      n_fail++; $display("FAIL w64_min_2: got q=%h r=%h want c000000000000000 0", q64, r64);
    end
    run_cmd64(1'b0, 64'h1234_5678_9ABC_DEF7, 64'h10, lat);
    n_checks++;
    if ({q64, r64} !== {64'h0123_4567_89AB_CDEF, 64'd7}) begin
      n_fail++; $display("FAIL w64_div16: got q=%h r=%h want 0123456789abcdef 7", q64, r64);
    end
  endtask

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  task automatic test_early_out();
    int   lat;
    logic rs;
    run_cmd(1'b0, 32'd3, 32'd10, lat, rs);
    n_checks++;
    if (lat > 3 || {out_quot, out_rem} !== {32'd0, 32'd3}) begin
      n_fail++; $display("FAIL early_3_10: got lat=%0d q=%0d r=%0d want lat<=3 q=0 r=3",
                         lat, out_quot, out_rem);
    end
    consume();
  endtask
`endif

  initial begin
    in_valid = 1'b0; in_signed = 1'b0; in_num = '0; in_denom = '0; in_result_ready = 1'b0;
    v64 = 1'b0; s64 = 1'b0; n64 = '0; d64 = '0; rr64 = 1'b0;
    test_reset();
    test_unsigned_latency();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    test_early_out();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
